// File: rtl/bitstream_pkg.sv
// Shared types and constants for the CABAC bitstream prefetch stage.
package bitstream_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StUnpack,
        StDrain
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [7:0] EPB_BYTE = 8'h03;
    localparam logic [7:0] PAD_BYTE = 8'h00;

    // Big-endian byte select: byte 0 is the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    word_byte = w[31:24];
            2'd1:    word_byte = w[23:16];
            2'd2:    word_byte = w[15:8];
            default: word_byte = w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-around pointers and an occupancy counter; synchronous active-low reset.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign free_cnt = CNT_W'(DEPTH) - count;
    assign pop_data = mem[rd_ptr];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/bitstream_prefetch.sv
// Fetches slice words, unpacks big-endian bytes, strips emulation-prevention bytes and serves
// them one per request to the CABAC decoder, padding with 0x00 plus eos once exhausted.
module bitstream_prefetch
    import bitstream_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_bytes,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_rd_valid,
    input  logic              request,
    output logic [7:0]        data,
    output logic              data_ready,
    output logic              eos,
    output logic              busy,
    output logic [7:0]        epb_count
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  raw_cnt_q;
    logic [LEN_W-1:0]  num_bytes_q;
    logic [31:0]       word_q;
    logic [1:0]        byte_idx_q;
    logic [1:0]        zero_run_q;
    logic              pending_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  free_cnt;
    logic [7:0]        fifo_rdata;

    logic [7:0]        cur_byte;
    logic              in_unpack;
    logic              drop;
    logic              byte_push;
    logic [LEN_W-1:0]  raw_next;
    logic              word_done;
    logic              raw_left;
    logic              can_fetch;
    logic              issue_rd;
    logic              active;
    logic              req_ok;
    logic              serve;
    logic              pop;
    logic              pad;
    logic              set_pending;

    always_comb begin
        cur_byte  = word_byte(word_q, byte_idx_q);
        in_unpack = (state_q == StUnpack);
        drop      = in_unpack && (cur_byte == EPB_BYTE) && (zero_run_q == 2'd2);
        byte_push = in_unpack && !drop;
        raw_next  = raw_cnt_q + LEN_W'(1);
        word_done = (byte_idx_q == 2'd3) || (raw_next == num_bytes_q);
        raw_left  = (raw_next != num_bytes_q);
        // Pops only ever add room, so ignoring a same-cycle pop keeps the gate safe.
        can_fetch = (free_cnt - CNT_W'(byte_push)) >= CNT_W'(WORD_BYTES);
        issue_rd  = can_fetch && ((state_q == StFetch) || (in_unpack && word_done && raw_left));

        active      = (state_q == StFetch) || (state_q == StWait) || in_unpack;
        req_ok      = request && !pending_q;
        serve       = pending_q || req_ok;
        pop         = serve && !fifo_empty;
        pad         = serve && fifo_empty && !active;
        set_pending = req_ok && fifo_empty && active;
    end

    assign busy = (state_q != StIdle);

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (byte_push && !fifo_full),
        .push_data (cur_byte),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .free_cnt  (free_cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            raw_cnt_q   <= '0;
            num_bytes_q <= '0;
            word_q      <= '0;
            byte_idx_q  <= '0;
            zero_run_q  <= '0;
            pending_q   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            data        <= '0;
            data_ready  <= 1'b0;
            eos         <= 1'b0;
            epb_count   <= '0;
        end else begin
            mem_rd_en  <= 1'b0;
            data_ready <= 1'b0;

            if (pop) begin
                data       <= fifo_rdata;
                eos        <= 1'b0;
                data_ready <= 1'b1;
                pending_q  <= 1'b0;
            end else if (pad) begin
                data       <= PAD_BYTE;
                eos        <= 1'b1;
                data_ready <= 1'b1;
                pending_q  <= 1'b0;
            end else if (set_pending) begin
                pending_q <= 1'b1;
            end

            if (issue_rd) begin
                mem_rd_en <= 1'b1;
                mem_addr  <= addr_q;
                addr_q    <= addr_q + ADDR_W'(1);
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        num_bytes_q <= num_bytes;
                        raw_cnt_q   <= '0;
                        zero_run_q  <= '0;
                        epb_count   <= '0;
                        if (num_bytes == '0) begin
                            state_q <= StDrain;
                        end else begin
                            // FIFO is always empty in idle, so the first read goes out at once.
                            mem_rd_en <= 1'b1;
                            mem_addr  <= base_addr;
                            addr_q    <= base_addr + ADDR_W'(1);
                            state_q   <= StWait;
                        end
                    end
                end
                StFetch: begin
                    if (issue_rd) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (mem_rd_valid) begin
                        word_q     <= mem_rd_data;
                        byte_idx_q <= '0;
                        state_q    <= StUnpack;
                    end
                end
                StUnpack: begin
                    raw_cnt_q  <= raw_next;
                    byte_idx_q <= byte_idx_q + 2'd1;
                    if (drop) begin
                        zero_run_q <= '0;
                        if (epb_count != 8'hFF) begin
                            epb_count <= epb_count + 8'd1;
                        end
                    end else if (cur_byte == 8'h00) begin
                        if (zero_run_q != 2'd2) begin
                            zero_run_q <= zero_run_q + 2'd1;
                        end
                    end else begin
                        zero_run_q <= '0;
                    end
                    if (word_done) begin
                        if (!raw_left) begin
                            state_q <= StDrain;
                        end else if (issue_rd) begin
                            state_q <= StWait;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                StDrain: begin
                    if (fifo_empty && !pending_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_prefetch.sv
// Self-checking bench: expected bytes are queued at stream start and compared on data_ready.
module tb_bitstream_prefetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [19:0] num_bytes;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        request;
    logic [7:0]  data;
    logic        data_ready;
    logic        eos;
    logic        busy;
    logic [7:0]  epb_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_words [64];
    int          lat = 2;
    int          rd_pulses = 0;
    int          overlap = 0;
    int          stray_req = 0;
    int          stray_done = 0;
    logic [8:0]  exp_q [$];

    always #5 clk = ~clk;

    bitstream_prefetch #(
        .DEPTH  (8),
        .ADDR_W (16),
        .LEN_W  (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .num_bytes    (num_bytes),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .request      (request),
        .data         (data),
        .data_ready   (data_ready),
        .eos          (eos),
        .busy         (busy),
        .epb_count    (epb_count)
    );

    // Memory model: fixed latency of lat cycles from mem_rd_en to mem_rd_valid.
    initial begin : mem_model
        int         cnt;
        logic       rd_busy;
        logic [5:0] a;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        rd_busy      = 1'b0;
        cnt          = 0;
        a            = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rd_valid = 1'b0;
            if (rd_busy) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = mem_words[a];
                    rd_busy      = 1'b0;
                end
            end else if (stray_req != stray_done) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = 32'h0303_0303;
                stray_done++;
            end
            if (mem_rd_en) begin
                rd_pulses++;
                if (rd_busy) overlap++;
                rd_busy = 1'b1;
                cnt     = lat;
                a       = mem_addr[5:0];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
    endtask

    task automatic push_pad();
        exp_q.push_back({1'b1, 8'h00});
    endtask

    // Issue one request; optionally require a specific request-to-data_ready latency.
    task automatic get_byte(input string tag, input int want_lat, input int max_wait);
        int         n;
        logic [8:0] e;
        request = 1'b1;
        cycle(1);
        request = 1'b0;
        n = 1;
        while (!data_ready && n < max_wait) begin
            cycle(1);
            n++;
        end
        if (!data_ready) begin
            check_eq({tag, ".timeout"}, 32'(data_ready), 32'd1);
        end else begin
            if (want_lat > 0) check_eq({tag, ".lat"}, 32'(n), 32'(want_lat));
            if (exp_q.size() == 0) begin
                check_eq({tag, ".unexpected"}, 32'(data_ready), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq({tag, ".data"}, 32'(data), 32'(e[7:0]));
                check_eq({tag, ".eos"}, 32'(eos), 32'(e[8]));
            end
            cycle(1);
            check_eq({tag, ".strobe1"}, 32'(data_ready), 32'd0);
        end
    endtask

    task automatic start_stream(input logic [15:0] a, input logic [19:0] n);
        base_addr = a;
        num_bytes = n;
        start     = 1'b1;
        cycle(1);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin
            cycle(1);
            n++;
        end
        check_eq({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".rd_en"}, 32'(mem_rd_en), 32'd0);
        check_eq({tag, ".addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, ".data"}, 32'(data), 32'd0);
        check_eq({tag, ".ready"}, 32'(data_ready), 32'd0);
        check_eq({tag, ".eos"}, 32'(eos), 32'd0);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".epb"}, 32'(epb_count), 32'd0);
    endtask

    initial begin : main
        int         rd_base;
        logic [7:0] b;
        for (int i = 0; i < 64; i++) mem_words[i] = 32'hDEAD_BEEF;
        mem_words[0]  = 32'h1122_3344;
        mem_words[1]  = 32'h5566_7788;
        mem_words[4]  = 32'h0000_0301;
        mem_words[5]  = 32'h0000_0303;
        mem_words[8]  = 32'hA1A2_A3A4;
        mem_words[9]  = 32'hA5A6_A7A8;
        mem_words[12] = 32'hC1C2_C3C4;
        for (int w = 0; w < 10; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(w * 4 + k + 1);
                mem_words[16 + w][31 - 8 * k -: 8] = b;
            end
        end
        mem_words[40] = 32'hD1D2_D3D4;

        reset = 1'b0; start = 1'b0; request = 1'b0; base_addr = '0; num_bytes = '0;
        cycle(2);
        reset = 1'b1;
        check_reset_outputs("reset");

        // Basic order, with start-to-read latency.
        lat = 2;
        push_exp(8'h11); push_exp(8'h22); push_exp(8'h33); push_exp(8'h44);
        push_exp(8'h55); push_exp(8'h66); push_exp(8'h77); push_exp(8'h88);
        push_pad();
        start_stream(16'd0, 20'd8);
        check_eq("basic.rd_en", 32'(mem_rd_en), 32'd1);
        check_eq("basic.addr", 32'(mem_addr), 32'd0);
        check_eq("basic.busy", 32'(busy), 32'd1);
        cycle(25);
        for (int i = 0; i < 8; i++) get_byte("basic", 1, 20);
        get_byte("basic.pad", 1, 20);
        wait_idle("basic");

        // EPB removal.
        push_exp(8'h00); push_exp(8'h00); push_exp(8'h01); push_pad();
        start_stream(16'd4, 20'd4);
        cycle(12);
        for (int i = 0; i < 4; i++) get_byte("epb", 1, 20);
        check_eq("epb.count", 32'(epb_count), 32'd1);
        wait_idle("epb");

        // Zero run restarts after a removed EPB.
        push_exp(8'h00); push_exp(8'h00); push_exp(8'h03); push_pad();
        start_stream(16'd5, 20'd4);
        cycle(12);
        for (int i = 0; i < 4; i++) get_byte("runrst", 1, 20);
        check_eq("runrst.count", 32'(epb_count), 32'd1);
        wait_idle("runrst");

        // Partial final word.
        rd_base = rd_pulses;
        for (int i = 0; i < 6; i++) push_exp(8'hA1 + 8'(i));
        push_pad();
        start_stream(16'd8, 20'd6);
        check_eq("partial.epbclr", 32'(epb_count), 32'd0);
        cycle(25);
        for (int i = 0; i < 7; i++) get_byte("partial", 1, 20);
        wait_idle("partial");
        check_eq("partial.reads", 32'(rd_pulses - rd_base), 32'd2);

        // Stalled memory: request into empty FIFO, valid in t -> data_ready in t+3.
        lat = 5;
        push_exp(8'hC1); push_exp(8'hC2); push_exp(8'hC3); push_exp(8'hC4); push_pad();
        start_stream(16'd12, 20'd4);
        get_byte("stall.pending", 8, 30);
        for (int i = 0; i < 4; i++) get_byte("stall", 0, 30);
        wait_idle("stall");

        // Fill gating: no requests, only two words fit.
        lat = 1;
        rd_base = rd_pulses;
        for (int i = 0; i < 40; i++) push_exp(8'(i + 1));
        push_pad();
        start_stream(16'd16, 20'd40);
        cycle(40);
        check_eq("gate.reads", 32'(rd_pulses - rd_base), 32'd2);
        check_eq("gate.rd_en", 32'(mem_rd_en), 32'd0);
        for (int i = 0; i < 41; i++) get_byte("gate", 0, 40);
        wait_idle("gate");
        check_eq("gate.total_reads", 32'(rd_pulses - rd_base), 32'd10);
        check_eq("overlap", 32'(overlap), 32'd0);

        // Reset mid-UNPACK, then a stray response and an eos request.
        start_stream(16'd40, 20'd4);
        cycle(3);
        reset = 1'b0;
        cycle(1);
        reset = 1'b1;
        check_reset_outputs("midrst");
        rd_base = rd_pulses;
        stray_req++;
        cycle(6);
        check_eq("midrst.stray_busy", 32'(busy), 32'd0);
        check_eq("midrst.stray_reads", 32'(rd_pulses - rd_base), 32'd0);
        push_pad();
        get_byte("midrst.pad", 1, 20);
        check_eq("scoreboard.left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitstream_prefetch.md
# bitstream_prefetch

Byte-supply stage directly upstream of the CABAC arithmetic decoder. Fetches 32-bit words of slice data from bitstream memory, unpacks them big-endian into bytes, removes emulation-prevention bytes, and buffers the result in a small byte FIFO. The decoder pulls one byte per `request` and receives it with a one-cycle `data_ready` strobe. Once the stream is exhausted, the block pads with 0x00 and flags `eos`.

## Interface
- `DEPTH`, 8 — byte FIFO entries; power of two, ≥ 8.
- `ADDR_W`, 16 — word-address width of the bitstream memory.
- `LEN_W`, 20 — width of the raw byte-count field.

- `clk`  in  1 — sole clock; all logic on rising edge.
- `reset`  in  1 — synchronous, active-low; low at a rising edge resets every register.
- `start`  in  1 — one-cycle pulse; latches `base_addr` and `num_bytes`; ignored while `busy`.
- `base_addr`  in  ADDR_W — word address of the first stream word.
- `num_bytes`  in  LEN_W — raw stream length in bytes, counted before EPB removal; 0 means an empty stream.
- `mem_rd_en`  out  1 — one-cycle read strobe; at most one read outstanding.
- `mem_addr`  out  ADDR_W — read address, valid with `mem_rd_en`.
- `mem_rd_data`  in  32 — returned word; byte 0 is bits [31:24].
- `mem_rd_valid`  in  1 — one-cycle strobe marking `mem_rd_data` valid; arbitrary latency ≥ 1.
- `request`  in  1 — decoder byte request (one-cycle pulse).
- `data`  out  8 — byte delivered; held until the next delivery.
- `data_ready`  out  1 — one-cycle strobe: `data` (and `eos`) valid.
- `eos`  out  1 — qualifies the current delivery as end-of-stream padding (`data` = 0x00).
- `busy`  out  1 — stream active.
- `epb_count`  out  8 — saturating count of EPBs removed in the current stream; cleared on `start`.

## Operation
- **Reset values:** `mem_rd_en` 0, `mem_addr` 0, `data` 0x00, `data_ready` 0, `eos` 0, `busy` 0, `epb_count` 0. FIFO empty, no pending request, FSM in IDLE.
- **FSM states:**
  - IDLE → FETCH on `start`. With `num_bytes` = 0, go directly to DRAIN.
  - FETCH: issue a read when FIFO free slots ≥ 4; increment the address; go to WAIT.
  - WAIT → UNPACK on `mem_rd_valid`, latching the word.
  - UNPACK: process one byte per cycle, bytes 0..3. Stop early when the raw byte counter reaches `num_bytes`; the remaining bytes of the word are discarded.
  - UNPACK exit: to FETCH if raw bytes remain, otherwise to DRAIN.
  - DRAIN → IDLE when the FIFO is empty and no delivery is pending.
- `busy` = state ≠ IDLE.
- **EPB filter:** `zero_run` is a 2-bit saturating counter, reset on `start`. For each processed byte:
  - Byte = 0x03 and `zero_run` = 2: drop the byte, set `zero_run` to 0, increment `epb_count`.
  - Byte = 0x00: push it, `zero_run` = min(`zero_run`+1, 2).
  - Any other byte: push it, `zero_run` = 0.
  - The raw counter increments for dropped bytes too.
- **Serve side:**
  - `request` with the FIFO non-empty pops the head.
  - `request` with the FIFO empty and state ∈ {FETCH, WAIT, UNPACK} sets `pending`; the pop happens on the first cycle the FIFO is non-empty.
  - `request` with the FIFO empty and state ∈ {IDLE, DRAIN} delivers 0x00 with `eos` = 1.
  - A `request` while `pending` or a delivery is in flight is ignored; the decoder must wait for `data_ready`.
- **Simultaneous push and pop:** allowed; occupancy is unchanged. A byte pushed in cycle t is poppable in t+1, not in t.
- **Overflow:** impossible by construction (fetch gating); the FIFO never asserts overflow.
- **Late responses:** `mem_rd_valid` in IDLE or DRAIN is ignored; this covers a response arriving after `reset`.

## Timing
- `start` in cycle t → `mem_rd_en` high in t+1.
- `mem_rd_valid` in t → byte 0 enters the FIFO at the end of t+1; byte k at the end of t+1+k.
- `request` in t with the FIFO non-empty → `data_ready` high in t+1, exactly one cycle.
- Pending request, first push at the end of t → pop in t+1 → `data_ready` in t+2.
- EOS padding: `request` in t → `data_ready` and `eos` in t+1.
- `eos` is low on non-padding deliveries.
- Sustained throughput:
  - Decoder side: one byte per 2 cycles, given the request/`data_ready` turnaround.
  - Fill side: up to 4 bytes per (memory latency + 5) cycles.
- Reset mid-operation: all outputs return to reset values at the next edge; in-flight read and FIFO contents are discarded.

## Structure
- **Shared package `bitstream_pkg`:** FSM state enum {IDLE, FETCH, WAIT, UNPACK, DRAIN}, `WORD_BYTES` = 4, `EPB_BYTE` = 8'h03, `PAD_BYTE` = 8'h00.
- **Sub-module `byte_fifo`:**
  - Parameters DEPTH and 8-bit data; synchronous active-low `reset`.
  - Ports: push, pop, full, empty, `free_cnt`.
  - Storage is a register array with wrap-around read/write pointers plus an occupancy counter (log2(DEPTH)+1 bits).
- **Top level:** FSM, address and raw counters, EPB filter, and serve/pending logic.

## Test plan
- **Basic order:** `base_addr` 0, `num_bytes` 8, memory words 0x11223344, 0x55667788, 8 requests → bytes 11,22,…,88, each `data_ready` one cycle after its request. A 9th request → 0x00 with `eos` = 1.
- **EPB removal:** word 0x00000301, `num_bytes` 4 → bytes 00,00,01; `epb_count` = 1.
- **Run reset after EPB:** word 0x00000303 → bytes 00,00,03. The second 0x03 is kept; `epb_count` = 1.
- **Partial word:** `num_bytes` 6, words 0xA1A2A3A4, 0xA5A6A7A8 → bytes A1..A6, then `eos` padding; only 2 `mem_rd_en` pulses.
- **Stalled memory with fill gating:**
  - Request into an empty FIFO, `mem_rd_valid` delayed 5 cycles to cycle t → `data_ready` in t+3.
  - With no requests, FIFO occupancy never exceeds 8, and `mem_rd_en` stays low while free slots < 4.
- **Reset mid-UNPACK:**
  - `reset` low for one cycle → all outputs at reset values.
  - A subsequent `mem_rd_valid` is ignored.
  - A following request returns 0x00 with `eos` = 1.
